// File: rtl/dut_batch_scheduler_pkg.sv
// Shared types for the DUT batch scheduler and the UART middleware.
// State encoding plus select/tag widths for the default 4-DUT build.
package dut_batch_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RDY,
    S_READ_ADR,
    S_READ_CAPT,
    S_PUSH,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int NUM_DUT_DEF = 4;
  localparam int ADR_W_DEF   = 6;
  localparam int SEL_W = $clog2(NUM_DUT_DEF) + 1;
  localparam int TAG_W = SEL_W + ADR_W_DEF;

  function automatic int sel_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dut_batch_scheduler_watchdog.sv
// Per-test watchdog: clearable counter that parks at LIMIT-1.
// TIMEOUT is only meaningful while counting is enabled.
module dut_watchdog #(
  parameter int LIMIT = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic TIMEOUT
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] TOP = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      cnt <= '0;
    end else if (EN && cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TIMEOUT = EN && (cnt == TOP);

endmodule

// File: rtl/dut_batch_scheduler.sv
// Batch sequencer: start each enabled DUT, wait for ready under a
// watchdog, then stream its result window out with {dut, adr} tags.
module dut_batch_scheduler
  import dut_batch_scheduler_pkg::*;
#(
  parameter int NUM_DUT         = 4,
  parameter int BITWIDTH_ADR    = 6,
  parameter int BITWIDTH_DATA   = 16,
  parameter int NUM_READ        = 4,
  parameter int BITWIDTH_REPEAT = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       CLK_SYS,
  input  logic                       RST,
  input  logic                       BATCH_START,
  input  logic [NUM_DUT-1:0]         BATCH_MASK,
  input  logic [BITWIDTH_REPEAT-1:0] BATCH_REPEAT,
  input  logic                       BATCH_ABORT,
  output logic                       BUSY,
  output logic                       BATCH_DONE,
  output logic                       TIMEOUT_ERR,
  output logic [$clog2(NUM_DUT):0]   ERR_SEL,
  output logic                       DUT_START,
  output logic [$clog2(NUM_DUT):0]   DUT_SEL,
  output logic [BITWIDTH_ADR-1:0]    DUT_ADR,
  output logic                       DUT_RnW,
  output logic [BITWIDTH_DATA-1:0]   DUT_DIN,
  input  logic [BITWIDTH_DATA-1:0]   DUT_DOUT,
  input  logic                       DUT_RDY,
  output logic                       RES_VALID,
  input  logic                       RES_READY,
  output logic [BITWIDTH_DATA-1:0]   RES_DATA,
  output logic [$clog2(NUM_DUT)+BITWIDTH_ADR:0] RES_TAG,
  output logic                       RES_LAST
);

  localparam int SW = sel_w(NUM_DUT);
  localparam logic [BITWIDTH_ADR-1:0] LAST_ADR =
    BITWIDTH_ADR'(NUM_READ - 1);
  localparam logic [BITWIDTH_REPEAT-1:0] REP_ONE =
    BITWIDTH_REPEAT'(1);

  state_t state, state_nx;

  logic [NUM_DUT-1:0]         mask;
  logic [BITWIDTH_REPEAT-1:0] rep;
  logic [SW-1:0]              sel;
  logic [SW-1:0]              err_sel;
  logic [BITWIDTH_ADR-1:0]    adr;
  logic [BITWIDTH_DATA-1:0]   hold;
  logic                       rdy_q;
  logic                       done_q;
  logic                       err;
  logic                       wd_to;
  logic                       rdy_edge;
  logic                       last_word;
  logic [SW-1:0]              first_idx;
  logic [SW-1:0]              low_idx;
  logic [SW-1:0]              up_idx;
  logic                       up_found;

  // Descending scan: the last hit is the lowest qualifying index.
  always_comb begin
    first_idx = '0;
    low_idx   = '0;
    up_idx    = '0;
    up_found  = 1'b0;
    for (int i = NUM_DUT - 1; i >= 0; i--) begin
      if (BATCH_MASK[i]) first_idx = SW'(i);
      if (mask[i]) low_idx = SW'(i);
      if (mask[i] && SW'(i) > sel) begin
        up_idx   = SW'(i);
        up_found = 1'b1;
      end
    end
  end

  assign rdy_edge  = DUT_RDY && !rdy_q;
  assign last_word = (adr == LAST_ADR) && (rep == REP_ONE) && !up_found;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (BATCH_START) begin
          state_nx = (|BATCH_MASK && |BATCH_REPEAT) ? S_START : S_DONE;
        end
      end
      S_START: state_nx = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (rdy_edge) state_nx = S_READ_ADR;
        else if (wd_to) state_nx = S_NEXT;
      end
      S_READ_ADR:  state_nx = S_READ_CAPT;
      S_READ_CAPT: state_nx = S_PUSH;
      S_PUSH: begin
        if (RES_READY) begin
          state_nx = (adr == LAST_ADR) ? S_NEXT : S_READ_ADR;
        end
      end
      S_NEXT: begin
        state_nx = (!up_found && rep <= REP_ONE) ? S_DONE : S_START;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (BATCH_ABORT) state_nx = S_IDLE;
  end

  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state   <= S_IDLE;
      mask    <= '0;
      rep     <= '0;
      sel     <= '0;
      adr     <= '0;
      hold    <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err     <= 1'b0;
      err_sel <= '0;
    end else begin
      state  <= state_nx;
      done_q <= (state == S_DONE) && !BATCH_ABORT;
      rdy_q  <= (state == S_START) ? 1'b1 : DUT_RDY;
      if (BATCH_ABORT) begin
        mask <= '0;
        rep  <= '0;
        sel  <= '0;
        adr  <= '0;
        hold <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (BATCH_START) begin
              mask    <= BATCH_MASK;
              rep     <= BATCH_REPEAT;
              sel     <= first_idx;
              adr     <= '0;
              err     <= 1'b0;
              err_sel <= '0;
            end
          end
          S_START: adr <= '0;
          S_WAIT_RDY: begin
            if (!rdy_edge && wd_to) begin
              err <= 1'b1;
              if (!err) err_sel <= sel;
            end
          end
          S_READ_CAPT: hold <= DUT_DOUT;
          S_PUSH: begin
            if (RES_READY && adr != LAST_ADR) adr <= adr + 1'b1;
          end
          S_NEXT: begin
            adr <= '0;
            if (up_found) begin
              sel <= up_idx;
            end else begin
              sel <= low_idx;
              if (rep != '0) rep <= rep - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  dut_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wd (
    .CLK(CLK_SYS),
    .RST(RST),
    .CLR((state == S_START) || BATCH_ABORT),
    .EN(state == S_WAIT_RDY),
    .TIMEOUT(wd_to)
  );

  assign BUSY        = (state != S_IDLE);
  assign BATCH_DONE  = done_q;
  assign TIMEOUT_ERR = err;
  assign ERR_SEL     = err_sel;
  assign DUT_START   = (state == S_START);
  assign DUT_SEL     = sel;
  assign DUT_ADR     = adr;
  assign DUT_RnW     = (state == S_READ_ADR);
  assign DUT_DIN     = '0;
  assign RES_VALID   = (state == S_PUSH);
  assign RES_DATA    = RES_VALID ? hold : '0;
  assign RES_TAG     = RES_VALID ? {sel, adr} : '0;
  assign RES_LAST    = RES_VALID && last_word;

endmodule

// File: tb/tb_dut_batch_scheduler.sv
// Scoreboard bench for dut_batch_scheduler with a behavioural test
// environment model and randomized ready/delay stimulus.
module tb_dut_batch_scheduler;

  typedef struct packed {
    logic [15:0] data;
    logic [8:0]  tag;
    logic        last;
  } word_t;

  logic        CLK_SYS;
  logic        RST;
  logic        BATCH_START;
  logic [3:0]  BATCH_MASK;
  logic [7:0]  BATCH_REPEAT;
  logic        BATCH_ABORT;
  logic        BUSY;
  logic        BATCH_DONE;
  logic        TIMEOUT_ERR;
  logic [2:0]  ERR_SEL;
  logic        DUT_START;
  logic [2:0]  DUT_SEL;
  logic [5:0]  DUT_ADR;
  logic        DUT_RnW;
  logic [15:0] DUT_DIN;
  logic [15:0] DUT_DOUT;
  logic        DUT_RDY;
  logic        RES_VALID;
  logic        RES_READY;
  logic [15:0] RES_DATA;
  logic [8:0]  RES_TAG;
  logic        RES_LAST;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int popped = 0;
  int pop_limit = 0;
  int ready_mode = 0;
  int env_run = 0;
  int last_start = 0;
  int to_diff = -1;
  bit rnd_delay = 0;
  logic [3:0] hang = '0;

  word_t      exp_q[$];
  logic [2:0] exp_start_q[$];

  dut_batch_scheduler #(
    .NUM_DUT(4),
    .BITWIDTH_ADR(6),
    .BITWIDTH_DATA(16),
    .NUM_READ(4),
    .BITWIDTH_REPEAT(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .CLK_SYS(CLK_SYS),
    .RST(RST),
    .BATCH_START(BATCH_START),
    .BATCH_MASK(BATCH_MASK),
    .BATCH_REPEAT(BATCH_REPEAT),
    .BATCH_ABORT(BATCH_ABORT),
    .BUSY(BUSY),
    .BATCH_DONE(BATCH_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ERR_SEL(ERR_SEL),
    .DUT_START(DUT_START),
    .DUT_SEL(DUT_SEL),
    .DUT_ADR(DUT_ADR),
    .DUT_RnW(DUT_RnW),
    .DUT_DIN(DUT_DIN),
    .DUT_DOUT(DUT_DOUT),
    .DUT_RDY(DUT_RDY),
    .RES_VALID(RES_VALID),
    .RES_READY(RES_READY),
    .RES_DATA(RES_DATA),
    .RES_TAG(RES_TAG),
    .RES_LAST(RES_LAST)
  );

  initial begin
    CLK_SYS = 0;
    forever #5 CLK_SYS = ~CLK_SYS;
  end

  initial forever begin
    @(posedge CLK_SYS);
    cyc++;
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got=%h want=nothing", nm, act);
  endtask

  // Test environment: ready rises some cycles after a start unless
  // the DUT is hung; read data returns one cycle after the address.
  initial begin
    logic st, rnw;
    logic [2:0] s, cur;
    logic [5:0] a;
    int cd;
    DUT_RDY = 0;
    DUT_DOUT = 0;
    cd = 0;
    cur = 0;
    forever begin
      @(negedge CLK_SYS);
      st = DUT_START;
      rnw = DUT_RnW;
      s = DUT_SEL;
      a = DUT_ADR;
      @(posedge CLK_SYS);
      #1;
      if (st) begin
        env_run++;
        cur = s;
        DUT_RDY = 0;
        cd = rnd_delay ? int'($urandom_range(15, 2)) : 10;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !hang[cur[1:0]]) DUT_RDY = 1;
      end
      DUT_DOUT = rnw ? {4'(s), 4'(a), 8'(env_run)} : 16'hDEAD;
    end
  end

  initial begin
    RES_READY = 0;
    forever begin
      @(posedge CLK_SYS);
      #1;
      case (ready_mode)
        0: RES_READY = 1;
        1: RES_READY = 1'($urandom_range(1, 0));
        default: RES_READY = (popped < pop_limit);
      endcase
    end
  end

  // Monitor: pops expectations on starts and accepted words.
  initial begin
    word_t w, pw;
    logic pv, pr, perr;
    pv = 0;
    pr = 0;
    perr = 0;
    pw = '0;
    forever begin
      @(negedge CLK_SYS);
      if (RST) begin
        pv = 0;
        perr = 0;
      end else begin
        if (BATCH_DONE) done_cnt++;
        if (DUT_START) begin
          last_start = cyc;
          if (exp_start_q.size() == 0) fail_now("start_unexpected", DUT_SEL);
          else check("start_sel", DUT_SEL, exp_start_q.pop_front());
        end
        if (TIMEOUT_ERR && !perr) to_diff = cyc - last_start;
        perr = TIMEOUT_ERR;
        w = {RES_DATA, RES_TAG, RES_LAST};
        if (RES_VALID) begin
          if (pv && !pr) check("hold_stable", w, pw);
          if (RES_READY) begin
            if (exp_q.size() == 0) fail_now("word_unexpected", w);
            else check("word", w, exp_q.pop_front());
            popped++;
          end
        end
        pv = RES_VALID;
        pr = RES_READY;
        pw = w;
      end
    end
  end

  function automatic void build_model(input logic [3:0] m,
                                      input logic [7:0] r);
    int run, hi;
    word_t x;
    run = env_run;
    hi = -1;
    for (int p = 0; p < int'(r); p++) begin
      for (int d = 0; d < 4; d++) begin
        if (m[d]) begin
          run++;
          exp_start_q.push_back(3'(d));
          if (!hang[d]) begin
            for (int a = 0; a < 4; a++) begin
              x.data = {4'(d), 4'(a), 8'(run)};
              x.tag = {3'(d), 6'(a)};
              x.last = 0;
              exp_q.push_back(x);
            end
          end
        end
      end
    end
    for (int d = 0; d < 4; d++) if (m[d]) hi = d;
    if (r != 0 && hi >= 0 && !hang[hi]) begin
      x = exp_q.pop_back();
      x.last = 1;
      exp_q.push_back(x);
    end
  endfunction

  function automatic logic [2:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic run_batch(input logic [3:0] m, input logic [7:0] r);
    int d0, n;
    logic [3:0] hit;
    build_model(m, r);
    d0 = done_cnt;
    to_diff = -1;
    @(negedge CLK_SYS);
    BATCH_MASK = m;
    BATCH_REPEAT = r;
    BATCH_START = 1;
    @(negedge CLK_SYS);
    BATCH_START = 0;
    check("start_latency", {BUSY, DUT_START}, 2'b11);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge CLK_SYS);
      n++;
    end
    repeat (3) @(negedge CLK_SYS);
    check("done_once", done_cnt - d0, 1);
    check("words_left", exp_q.size(), 0);
    check("starts_left", exp_start_q.size(), 0);
    hit = m & hang;
    check("timeout_err", TIMEOUT_ERR, hit != 0);
    check("err_sel", ERR_SEL, lowest(hit));
    exp_q.delete();
    exp_start_q.delete();
  endtask

  initial begin
    int d0, n;
    RST = 1;
    BATCH_START = 0;
    BATCH_MASK = 0;
    BATCH_REPEAT = 0;
    BATCH_ABORT = 0;
    repeat (3) @(negedge CLK_SYS);
    check("reset_outputs",
          {BUSY, BATCH_DONE, TIMEOUT_ERR, ERR_SEL, DUT_START, DUT_SEL,
           DUT_ADR, DUT_RnW, DUT_DIN, RES_VALID, RES_DATA, RES_TAG,
           RES_LAST}, '0);
    RST = 0;
    @(negedge CLK_SYS);

    run_batch(4'b0101, 8'd1);
    run_batch(4'b0010, 8'd3);

    hang = 4'b0001;
    run_batch(4'b0011, 8'd1);
    check("timeout_delay", to_diff, 51);
    hang = 4'b0000;

    ready_mode = 1;
    rnd_delay = 1;
    for (int k = 0; k < 6; k++) begin
      run_batch(4'($urandom_range(15, 1)), 8'($urandom_range(3, 1)));
    end
    rnd_delay = 0;

    ready_mode = 2;
    pop_limit = popped + 2;
    build_model(4'b0001, 8'd1);
    @(negedge CLK_SYS);
    BATCH_MASK = 4'b0001;
    BATCH_REPEAT = 8'd1;
    BATCH_START = 1;
    @(negedge CLK_SYS);
    BATCH_START = 0;
    n = 0;
    while (!(RES_VALID && RES_TAG[5:0] == 6'd2) && n < 500) begin
      @(negedge CLK_SYS);
      n++;
    end
    check("abort_reach_word2", n < 500, 1);
    BATCH_ABORT = 1;
    d0 = done_cnt;
    @(posedge CLK_SYS);
    #1;
    BATCH_ABORT = 0;
    @(negedge CLK_SYS);
    check("abort_idle", {BUSY, RES_VALID, DUT_START, DUT_SEL}, '0);
    check("abort_words_left", exp_q.size(), 2);
    exp_q.delete();
    exp_start_q.delete();
    repeat (5) @(negedge CLK_SYS);
    check("abort_no_done", done_cnt, d0);
    ready_mode = 0;
    run_batch(4'b1011, 8'd1);

    @(negedge CLK_SYS);
    BATCH_MASK = 4'b0000;
    BATCH_REPEAT = 8'd1;
    BATCH_START = 1;
    @(negedge CLK_SYS);
    BATCH_START = 0;
    check("zero_mask_c1", {BUSY, DUT_START, BATCH_DONE}, 3'b100);
    @(negedge CLK_SYS);
    check("zero_mask_c2", BATCH_DONE, 1);
    @(negedge CLK_SYS);
    check("zero_mask_c3", {BUSY, BATCH_DONE}, 2'b00);

    d0 = done_cnt;
    BATCH_MASK = 4'b0001;
    BATCH_START = 1;
    BATCH_ABORT = 1;
    @(negedge CLK_SYS);
    BATCH_START = 0;
    BATCH_ABORT = 0;
    check("start_abort_idle", {BUSY, DUT_START}, 2'b00);
    repeat (5) @(negedge CLK_SYS);
    check("start_abort_no_done", done_cnt, d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
